padlock_seq: RTL and testbench

Parametrised sequential combination lock and the next generation of the fixed four-digit padlock in the lab designs. It takes digits one per `code_valid` strobe and compares the full entry against a stored, reprogrammable combination, never revealing which digit was wrong. It counts failed attempts and locks the keypad out for a fixed time once the limit is reached. It auto-relocks after inactivity and drives registered `unlock`/`err` status to the board LEDs.

---
 rtl/padlock_seq.sv | 157 +++++++++++++++
 tb/tb_padlock_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/padlock_seq.sv
// Sequential combination lock: digit-by-digit entry against a reprogrammable
// combination, with failed-attempt lockout and inactivity auto-relock.
module padlock_seq #(
    parameter int DIGIT_W        = 4,
    parameter int CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1842,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int IDLE_CYCLES    = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           code_valid,
    input  logic [DIGIT_W-1:0]             code,
    input  logic                           prog_en,
    input  logic                           relock,
    output logic                           unlock,
    output logic                           err,
    output logic                           locked_out,
    output logic                           prog_done,
    output logic [$clog2(MAX_TRIES+1)-1:0] attempts_left
);
    localparam int IW   = $clog2(CODE_LEN);
    localparam int AW   = $clog2(MAX_TRIES+1);
    localparam int TMAX = (IDLE_CYCLES > LOCKOUT_CYCLES) ? IDLE_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX+1);

    typedef enum logic [1:0] {ENTRY, UNLOCKED, PROG, LOCKOUT} state_t;

    state_t                             state_q, state_d;
    logic [IW-1:0]                      idx_q, idx_d;
    logic                               mis_q, mis_d;
    logic [CODE_LEN-1:0][DIGIT_W-1:0]   combo_q, combo_d, shadow_q, shadow_d;
    logic [AW-1:0]                      att_d;
    logic [TW-1:0]                      timer_q, timer_d;
    logic                               fail, commit, last, idle_hit, lock_hit;
    logic                               unlock_d, err_d, locked_d, done_d;

    assign last     = (idx_q == IW'(CODE_LEN-1));
    // a digit arriving in the expiry cycle wins, so expiry requires no strobe
    assign idle_hit = (state_q != LOCKOUT) && !code_valid && (timer_q == TW'(IDLE_CYCLES-1));
    assign lock_hit = (state_q == LOCKOUT) && (timer_q == TW'(LOCKOUT_CYCLES-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ENTRY;
            idx_q         <= '0;
            mis_q         <= 1'b0;
            combo_q       <= DEFAULT_CODE;
            shadow_q      <= '0;
            attempts_left <= AW'(MAX_TRIES);
            timer_q       <= '0;
            unlock        <= 1'b0;
            err           <= 1'b0;
            locked_out    <= 1'b0;
            prog_done     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mis_q         <= mis_d;
            combo_q       <= combo_d;
            shadow_q      <= shadow_d;
            attempts_left <= att_d;
            timer_q       <= timer_d;
            unlock        <= unlock_d;
            err           <= err_d;
            locked_out    <= locked_d;
            prog_done     <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        combo_d  = combo_q;
        shadow_d = shadow_q;
        att_d    = attempts_left;
        fail     = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ENTRY: begin
                if (relock || idle_hit) begin
                    idx_d = '0;
                    mis_d = 1'b0;
                end else if (code_valid) begin
                    // every digit is consumed so timing never reveals the bad one
                    if (last) begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (mis_q || (code != combo_q[idx_q])) begin
                            fail  = 1'b1;
                            att_d = attempts_left - 1'b1;
                            if (attempts_left == AW'(1)) state_d = LOCKOUT;
                        end else begin
                            state_d = UNLOCKED;
                            att_d   = AW'(MAX_TRIES);
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        mis_d = mis_q | (code != combo_q[idx_q]);
                    end
                end
            end
            UNLOCKED: begin
                if (relock || idle_hit) begin
                    state_d = ENTRY;
                end else if (code_valid && prog_en) begin
                    shadow_d[0] = code;
                    idx_d       = IW'(1);
                    state_d     = PROG;
                end
            end
            PROG: begin
                if (relock || idle_hit) begin
                    state_d = ENTRY;
                    idx_d   = '0;
                end else if (!prog_en) begin
                    state_d = UNLOCKED;
                    idx_d   = '0;
                end else if (code_valid) begin
                    shadow_d[idx_q] = code;
                    if (last) begin
                        combo_d = shadow_d;
                        commit  = 1'b1;
                        state_d = UNLOCKED;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOCKOUT: begin
                if (lock_hit) begin
                    state_d = ENTRY;
                    att_d   = AW'(MAX_TRIES);
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    // one shared timer: idle count outside LOCKOUT, lockout duration inside it
    always_comb begin
        if ((state_d != state_q) || idle_hit || (code_valid && state_q != LOCKOUT))
            timer_d = '0;
        else
            timer_d = timer_q + 1'b1;
    end

    always_comb begin
        unlock_d = (state_d == UNLOCKED) || (state_d == PROG);
        locked_d = (state_d == LOCKOUT);
        err_d    = fail;
        done_d   = commit;
    end
endmodule

// File: tb/tb_padlock_seq.sv
// Directed bench for padlock_seq: default code, mismatch, lockout,
// programming, aborts, partial abandon and asynchronous reset.
module tb_padlock_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       code_valid = 1'b0;
    logic [3:0] code = '0;
    logic       prog_en = 1'b0;
    logic       relock = 1'b0;
    logic       unlock, err, locked_out, prog_done;
    logic [1:0] attempts_left;
    int         n_chk = 0;
    int         n_fail = 0;

    padlock_seq dut (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
        .prog_en(prog_en), .relock(relock), .unlock(unlock), .err(err),
        .locked_out(locked_out), .prog_done(prog_done), .attempts_left(attempts_left)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // inputs change 1 time unit after a rising edge; outputs are read at the same point
    task automatic send(input logic [3:0] d);
        code_valid = 1'b1;
        code = d;
        @(posedge clk); #1;
        code_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_relock();
        relock = 1'b1;
        @(posedge clk); #1;
        relock = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #13;
        n_chk++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL reset_unlock: got %b want 0", unlock); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_chk++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL reset_locked_out: got %b want 0", locked_out); end
        n_chk++; if (prog_done !== 1'b0) begin n_fail++; $display("FAIL reset_prog_done: got %b want 0", prog_done); end
        n_chk++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL reset_attempts: got %0d want 3", attempts_left); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_default_code();
        send(4'h2); send(4'h4); send(4'h8);
        n_chk++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL early_unlock: got %b want 0", unlock); end
        send(4'h1);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL default_unlock: got %b want 1", unlock); end
        n_chk++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL default_attempts: got %0d want 3", attempts_left); end
        idle(31);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL idle31_unlock: got %b want 1", unlock); end
        idle(1);
        n_chk++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL idle32_relock: got %b want 0", unlock); end
    endtask

    task automatic test_late_mismatch();
        send(4'h2); send(4'h4); send(4'h8);
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL early_err: got %b want 0", err); end
        send(4'h3);
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL late_err: got %b want 1", err); end
        n_chk++; if (attempts_left !== 2'd2) begin n_fail++; $display("FAIL late_attempts: got %0d want 2", attempts_left); end
        n_chk++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL late_unlock: got %b want 0", unlock); end
        idle(1);
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_width: got %b want 0", err); end
    endtask

    task automatic test_lockout();
        send(4'h2); send(4'h4); send(4'h8); send(4'h3);
        n_chk++; if (attempts_left !== 2'd1) begin n_fail++; $display("FAIL lock_att1: got %0d want 1", attempts_left); end
        send(4'h0); send(4'h4); send(4'h8); send(4'h1);
        n_chk++; if (locked_out !== 1'b1) begin n_fail++; $display("FAIL lock_enter: got %b want 1", locked_out); end
        n_chk++; if (attempts_left !== 2'd0) begin n_fail++; $display("FAIL lock_att0: got %0d want 0", attempts_left); end
        send(4'h2); send(4'h4); send(4'h8); send(4'h1);
        n_chk++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL lock_ignores_code: got %b want 0", unlock); end
        idle(11);
        n_chk++; if (locked_out !== 1'b1) begin n_fail++; $display("FAIL lock_cycle15: got %b want 1", locked_out); end
        idle(1);
        n_chk++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL lock_cycle16: got %b want 0", locked_out); end
        n_chk++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL lock_reload: got %0d want 3", attempts_left); end
        send(4'h2); send(4'h4); send(4'h8); send(4'h1);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL post_lock_unlock: got %b want 1", unlock); end
    endtask

    task automatic test_programming();
        prog_en = 1'b1;
        send(4'h5); send(4'h5); send(4'h7);
        n_chk++; if (prog_done !== 1'b0) begin n_fail++; $display("FAIL prog_early_done: got %b want 0", prog_done); end
        send(4'h9);
        n_chk++; if (prog_done !== 1'b1) begin n_fail++; $display("FAIL prog_done: got %b want 1", prog_done); end
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL prog_unlock: got %b want 1", unlock); end
        idle(1);
        n_chk++; if (prog_done !== 1'b0) begin n_fail++; $display("FAIL prog_done_width: got %b want 0", prog_done); end
        prog_en = 1'b0;
        do_relock();
        n_chk++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL relock: got %b want 0", unlock); end
        send(4'h5); send(4'h5); send(4'h7); send(4'h9);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL new_code_unlock: got %b want 1", unlock); end
        do_relock();
        send(4'h2); send(4'h4); send(4'h8); send(4'h1);
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL old_code_err: got %b want 1", err); end
        n_chk++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL old_code_unlock: got %b want 0", unlock); end
    endtask

    task automatic test_reset_loses_code();
        reset = 1'b0; #2; reset = 1'b1;
        @(posedge clk); #1;
        send(4'h5); send(4'h5); send(4'h7); send(4'h9);
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL prog_lost_err: got %b want 1", err); end
        send(4'h2); send(4'h4); send(4'h8); send(4'h1);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL default_restored: got %b want 1", unlock); end
    endtask

    task automatic test_aborted_prog();
        prog_en = 1'b1;
        send(4'h7); send(4'h7);
        prog_en = 1'b0;
        idle(1);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL abort_stays_unlocked: got %b want 1", unlock); end
        n_chk++; if (prog_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", prog_done); end
        do_relock();
        send(4'h2); send(4'h4); send(4'h8); send(4'h1);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL abort_code_kept: got %b want 1", unlock); end
        // relock with a simultaneous digit while unlocked: locks, no PROG
        prog_en = 1'b1; relock = 1'b1; code_valid = 1'b1; code = 4'h5;
        @(posedge clk); #1;
        relock = 1'b0; code_valid = 1'b0; prog_en = 1'b0;
        n_chk++; if (unlock !== 1'b0) begin n_fail++; $display("FAIL relock_beats_digit: got %b want 0", unlock); end
        // same in ENTRY: the 2 is discarded, so the next four digits form a full attempt
        relock = 1'b1; code_valid = 1'b1; code = 4'h2;
        @(posedge clk); #1;
        relock = 1'b0; code_valid = 1'b0;
        send(4'h2); send(4'h4); send(4'h8); send(4'h1);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL relock_digit_ignored: got %b want 1", unlock); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL relock_digit_err: got %b want 0", err); end
    endtask

    task automatic test_partial_abandon();
        do_relock();
        send(4'h2); send(4'h4);
        idle(32);
        send(4'h2); send(4'h4); send(4'h8); send(4'h1);
        n_chk++; if (unlock !== 1'b1) begin n_fail++; $display("FAIL abandon_unlock: got %b want 1", unlock); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL abandon_err: got %b want 0", err); end
        n_chk++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL abandon_attempts: got %0d want 3", attempts_left); end
    endtask

    task automatic test_async_reset_lockout();
        do_relock();
        for (int i = 0; i < 3; i++) begin
            send(4'h1); send(4'h1); send(4'h1); send(4'h1);
        end
        n_chk++; if (locked_out !== 1'b1) begin n_fail++; $display("FAIL lock2_enter: got %b want 1", locked_out); end
        idle(3);
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (locked_out !== 1'b0) begin n_fail++; $display("FAIL async_locked_out: got %b want 0", locked_out); end
        n_chk++; if (attempts_left !== 2'd3) begin n_fail++; $display("FAIL async_attempts: got %0d want 3", attempts_left); end
        n_chk++; if (unlock !== 1'b0 || err !== 1'b0 || prog_done !== 1'b0) begin
            n_fail++; $display("FAIL async_others: got unlock=%b err=%b done=%b want 0", unlock, err, prog_done);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_default_code();
        test_late_mismatch();
        test_lockout();
        test_programming();
        test_reset_loses_code();
        test_aborted_prog();
        test_partial_abandon();
        test_async_reset_lockout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
